// File: rtl/nic_port_lookup.sv
// nic_port_lookup: buffers the arbiter's merged packet stream, rewrites the
// destination-port field of each IOQ module header so MAC port i is sent to
// its paired CPU queue (i XOR 1) and vice versa, and counts packets.
module nic_port_lookup #(
    parameter int                        DATA_WIDTH         = 64,
    parameter int                        CTRL_WIDTH         = DATA_WIDTH / 8,
    parameter logic [CTRL_WIDTH-1:0]     IO_QUEUE_STAGE_NUM = 8'hFF,
    parameter int                        NUM_OUTPUT_QUEUES  = 8,
    parameter int                        FIFO_DEPTH_BITS    = 2
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [CTRL_WIDTH-1:0] in_ctrl,
    input  logic                  in_wr,
    output logic                  in_rdy,

    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CTRL_WIDTH-1:0] out_ctrl,
    output logic                  out_wr,
    input  logic                  out_rdy,

    output logic [31:0]           pkt_count,
    output logic [15:0]           bad_src_count
);

    localparam int                 DEPTH      = 1 << FIFO_DEPTH_BITS;
    localparam int                 CNT_W      = FIFO_DEPTH_BITS + 1;
    localparam logic [CNT_W-1:0]   CNT_FULL   = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]   CNT_NEARLY = CNT_W'(DEPTH - 1);
    localparam logic [15:0]        NUM_Q16    = 16'(NUM_OUTPUT_QUEUES);

    typedef enum logic [0:0] {
        MODULE_HDRS,
        IN_PACKET
    } state_t;

    state_t state, state_next;

    // Input buffer storage and bookkeeping
    logic [DATA_WIDTH-1:0]      data_mem [DEPTH];
    logic [CTRL_WIDTH-1:0]      ctrl_mem [DEPTH];
    logic [FIFO_DEPTH_BITS-1:0] wr_ptr;
    logic [FIFO_DEPTH_BITS-1:0] rd_ptr;
    logic [CNT_W-1:0]           fifo_count;

    logic                  push;
    logic                  pop;
    logic [DATA_WIDTH-1:0] head_data;
    logic [CTRL_WIDTH-1:0] head_ctrl;

    // Header rewrite results
    logic [15:0]           src_port;
    logic [15:0]           dst_field;
    logic [DATA_WIDTH-1:0] word_data;
    logic                  pkt_inc;
    logic                  bad_inc;

    // A write into a full buffer is dropped; in_rdy leaves one slot of slack
    // for a word the arbiter may already have in flight.
    assign push      = in_wr && (fifo_count != CNT_FULL);
    assign pop       = (fifo_count != '0) && out_rdy;
    assign in_rdy    = (fifo_count < CNT_NEARLY);
    assign head_data = data_mem[rd_ptr];
    assign head_ctrl = ctrl_mem[rd_ptr];
    assign src_port  = head_data[31:16];

    // Buffer storage write port
    // NOTE: the storage array has no reset; the pointers and count define
    // which entries are valid, so clearing them empties the buffer.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr] <= in_data;
            ctrl_mem[wr_ptr] <= in_ctrl;
        end
    end

    // Buffer pointers and occupancy
    // NOTE: all clocked state uses non-blocking assignment so every register
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + FIFO_DEPTH_BITS'(1);
            if (pop)  rd_ptr <= rd_ptr + FIFO_DEPTH_BITS'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Parser state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= MODULE_HDRS;
        else       state <= state_next;
    end

    // Next-state, header rewrite and counter strobes for the popped word
    // NOTE: every output of this block gets a default first, so no path
    // leaves a value held and no latch is inferred.
    always_comb begin
        state_next = state;
        word_data  = head_data;
        pkt_inc    = 1'b0;
        bad_inc    = 1'b0;
        dst_field  = '0;

        // One-hot of the paired port, NUM_OUTPUT_QUEUES wide, zero-extended
        for (int i = 0; i < NUM_OUTPUT_QUEUES; i++) begin
            if (16'(i) == (src_port ^ 16'd1)) dst_field[i] = 1'b1;
        end

        if (pop) begin
            case (state)
                MODULE_HDRS: begin
                    if (head_ctrl == IO_QUEUE_STAGE_NUM) begin
                        if (src_port < NUM_Q16) begin
                            word_data[63:48] = dst_field;
                        end else begin
                            word_data[63:48] = '0;
                            bad_inc          = 1'b1;
                        end
                    end else if (head_ctrl == '0) begin
                        state_next = IN_PACKET;
                    end
                end
                IN_PACKET: begin
                    if (head_ctrl != '0) begin
                        pkt_inc    = 1'b1;
                        state_next = MODULE_HDRS;
                    end
                end
                default: state_next = MODULE_HDRS;
            endcase
        end
    end

    // Registered output word; out_wr pulses once per popped word
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_wr   <= 1'b0;
            out_data <= '0;
            out_ctrl <= '0;
        end else begin
            out_wr <= pop;
            if (pop) begin
                out_data <= word_data;
                out_ctrl <= head_ctrl;
            end
        end
    end

    // Packet and bad-source counters, updated with the word's out_wr
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pkt_count     <= '0;
            bad_src_count <= '0;
        end else begin
            if (pkt_inc) pkt_count     <= pkt_count + 32'd1;
            if (bad_inc) bad_src_count <= bad_src_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_nic_port_lookup.sv
// tb_nic_port_lookup: directed stimulus with a scoreboard queue; a monitor
// pops expected words whenever out_wr is seen and compares them.
module tb_nic_port_lookup;

    localparam int DW = 64;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_ctrl;
    logic          in_wr;
    logic          in_rdy;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_ctrl;
    logic          out_wr;
    logic          out_rdy;
    logic [31:0]   pkt_count;
    logic [15:0]   bad_src_count;

    typedef struct packed {
        logic [CW-1:0] ctrl;
        logic [DW-1:0] data;
    } word_t;

    word_t exp_q[$];
    int    n_checks      = 0;
    int    n_fail        = 0;
    int    cyc           = 0;
    int    in_cyc        = -1;
    int    first_out_cyc = -1;
    int    exp_pkt       = 0;
    int    exp_bad       = 0;

    nic_port_lookup dut (
        .clk           (clk),
        .reset         (reset),
        .in_data       (in_data),
        .in_ctrl       (in_ctrl),
        .in_wr         (in_wr),
        .in_rdy        (in_rdy),
        .out_data      (out_data),
        .out_ctrl      (out_ctrl),
        .out_wr        (out_wr),
        .out_rdy       (out_rdy),
        .pkt_count     (pkt_count),
        .bad_src_count (bad_src_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one word; waits for in_rdy unless ignore_rdy. Leaves in_wr high.
    task automatic send_word(input logic [CW-1:0] ctrl, input logic [DW-1:0] data,
                             input logic [DW-1:0] exp_data, input bit expect_it,
                             input bit ignore_rdy);
        int guard;
        guard = 0;
        if (!ignore_rdy) begin
            while (!in_rdy) begin
                in_wr = 1'b0;
                @(posedge clk); #1;
                guard++;
                if (guard > 200) begin
                    $display("FAIL in_rdy_wait: got in_rdy=0 expected 1 within 200 cycles");
                    $fatal(1, "in_rdy never returned");
                end
            end
        end
        in_wr   = 1'b1;
        in_ctrl = ctrl;
        in_data = data;
        if (expect_it) exp_q.push_back('{ctrl: ctrl, data: exp_data});
        @(posedge clk); #1;
    endtask

    task automatic stop_wr();
        in_wr   = 1'b0;
        in_ctrl = '0;
        in_data = '0;
    endtask

    // IOQ header, one payload word, eop word
    task automatic send_pkt(input logic [DW-1:0] hdr, input logic [DW-1:0] exp_hdr,
                            input logic [DW-1:0] pay, input logic [DW-1:0] eop);
        send_word(8'hFF, hdr, exp_hdr, 1'b1, 1'b0);
        send_word(8'h00, pay, pay, 1'b1, 1'b0);
        send_word(8'h80, eop, eop, 1'b1, 1'b0);
        exp_pkt++;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 100) begin
            @(negedge clk);
            g++;
        end
        check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_counters(input string tag);
        check({tag, "_pkt_count"}, 64'(pkt_count), 64'(exp_pkt));
        check({tag, "_bad_src_count"}, 64'(bad_src_count), 64'(exp_bad));
    endtask

    // Monitor: compare every presented word with the scoreboard head
    initial begin
        word_t w;
        forever begin
            @(negedge clk);
            if (!reset && out_wr) begin
                if (first_out_cyc < 0) first_out_cyc = cyc;
                if (exp_q.size() == 0) begin
                    check("unexpected_out_wr", 64'(out_wr), 64'd0);
                end else begin
                    w = exp_q.pop_front();
                    check("out_data", out_data, w.data);
                    check("out_ctrl", 64'(out_ctrl), 64'(w.ctrl));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit");
    end

    logic [DW-1:0] tog_hdr [3];
    logic [DW-1:0] tog_exp [3];

    initial begin
        tog_hdr[0] = 64'h0000_0000_0000_0101; tog_exp[0] = 64'h0002_0000_0000_0101;
        tog_hdr[1] = 64'h0000_0000_0001_0202; tog_exp[1] = 64'h0001_0000_0001_0202;
        tog_hdr[2] = 64'h0000_0000_0004_0303; tog_exp[2] = 64'h0020_0000_0004_0303;

        reset   = 1'b1;
        in_wr   = 1'b0;
        in_data = '0;
        in_ctrl = '0;
        out_rdy = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Reset state
        check("rst_out_wr", 64'(out_wr), 64'd0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_out_ctrl", 64'(out_ctrl), 64'd0);
        check_counters("rst");
        reset = 1'b0;
        @(posedge clk); #1;
        check("in_rdy_after_release", 64'(in_rdy), 64'd1);

        // src=0 -> dst 0x0002, plus first-word latency
        in_cyc = cyc;
        send_pkt(64'h0000_0000_0000_0004, 64'h0002_0000_0000_0004,
                 64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888);
        stop_wr();
        drain();
        check("latency_cycles", 64'(first_out_cyc - in_cyc), 64'd2);
        check_counters("src0");

        // src=3 -> 0x0004, src=7 -> 0x0040, src=9 -> 0 and bad count
        send_pkt(64'h0000_0000_0003_0010, 64'h0004_0000_0003_0010,
                 64'hA0A0_A0A0_A0A0_A0A0, 64'hA1A1_A1A1_A1A1_A1A1);
        send_pkt(64'h0000_0000_0007_0020, 64'h0040_0000_0007_0020,
                 64'hB0B0_B0B0_B0B0_B0B0, 64'hB1B1_B1B1_B1B1_B1B1);
        send_pkt(64'h1234_0000_0009_0030, 64'h0000_0000_0009_0030,
                 64'hC0C0_C0C0_C0C0_C0C0, 64'hC1C1_C1C1_C1C1_C1C1);
        exp_bad++;
        stop_wr();
        drain();
        check_counters("src_3_7_9");

        // Other module header ahead of the IOQ header; payload that
        // resembles a header passes untouched
        send_word(8'h10, 64'hFFFF_0000_0001_0000, 64'hFFFF_0000_0001_0000, 1'b1, 1'b0);
        send_word(8'hFF, 64'h0000_0000_0001_0008, 64'h0001_0000_0001_0008, 1'b1, 1'b0);
        send_word(8'h00, 64'hDEAD_BEEF_0003_0000, 64'hDEAD_BEEF_0003_0000, 1'b1, 1'b0);
        send_word(8'h01, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 1'b1, 1'b0);
        exp_pkt++;
        // Header with non-zero surrounding bits: only [63:48] changes
        send_pkt(64'hFFFF_ABCD_0002_0040, 64'h0008_ABCD_0002_0040,
                 64'hD0D0_D0D0_D0D0_D0D0, 64'hD1D1_D1D1_D1D1_D1D1);
        stop_wr();
        drain();
        check_counters("extra_hdr");

        // Fill with out_rdy low: in_rdy drops at 3, 4th accepted, 5th dropped
        out_rdy = 1'b0;
        send_word(8'hFF, 64'h0000_0000_0006_00AA, 64'h0080_0000_0006_00AA, 1'b1, 1'b0);
        send_word(8'h00, 64'hE0E0_E0E0_E0E0_E0E0, 64'hE0E0_E0E0_E0E0_E0E0, 1'b1, 1'b0);
        send_word(8'h00, 64'hE1E1_E1E1_E1E1_E1E1, 64'hE1E1_E1E1_E1E1_E1E1, 1'b1, 1'b0);
        check("in_rdy_three_filled", 64'(in_rdy), 64'd0);
        send_word(8'h80, 64'hE2E2_E2E2_E2E2_E2E2, 64'hE2E2_E2E2_E2E2_E2E2, 1'b1, 1'b1);
        send_word(8'h20, 64'h0000_0000_0000_0BAD, 64'h0000_0000_0000_0BAD, 1'b0, 1'b1);
        exp_pkt++;
        stop_wr();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_out_wr", 64'(out_wr), 64'd0);
        end
        check("in_rdy_full", 64'(in_rdy), 64'd0);
        @(posedge clk); #1;
        out_rdy = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("resume_out_wr", 64'(out_wr), 64'd1);
        end
        @(negedge clk);
        check("after_drain_out_wr", 64'(out_wr), 64'd0);
        drain();
        check_counters("full");

        // Back-to-back packets with out_rdy toggling every cycle
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    @(posedge clk); #1;
                    out_rdy = ~out_rdy;
                end
            end
            begin
                for (int p = 0; p < 3; p++) begin
                    send_pkt(tog_hdr[p], tog_exp[p],
                             64'hF000_0000_0000_0000 | 64'(p),
                             64'hF100_0000_0000_0000 | 64'(p));
                end
                stop_wr();
            end
        join
        out_rdy = 1'b1;
        drain();
        check_counters("toggle");

        // Asynchronous reset in the middle of a packet
        send_word(8'hFF, 64'h0000_0000_0004_0000, 64'h0020_0000_0004_0000, 1'b1, 1'b0);
        send_word(8'h00, 64'h9999_9999_9999_9999, 64'h9999_9999_9999_9999, 1'b1, 1'b0);
        stop_wr();
        #2;
        reset = 1'b1;
        exp_q.delete();
        exp_pkt = 0;
        exp_bad = 0;
        #1;
        check("midrst_out_wr", 64'(out_wr), 64'd0);
        check("midrst_in_rdy", 64'(in_rdy), 64'd1);
        check_counters("midrst");
        @(posedge clk); #2;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_idle_out_wr", 64'(out_wr), 64'd0);
        end
        @(posedge clk); #1;
        send_pkt(64'h0000_0000_0005_0000, 64'h0010_0000_0005_0000,
                 64'h7777_0000_0000_0001, 64'h7777_0000_0000_0002);
        stop_wr();
        drain();
        check_counters("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
